usb_rst_sequencer: RTL and testbench
====================================

// Module: usb_rst_sequencer
// PURPOSE
//  Sits directly downstream of the 1-bit USB-reset PIO: consumes its out_port level
//  (software reset request) and drives the USB host controller reset pin with
//  guaranteed timing. Enforces a minimum reset-assert width and a post-release
//  settle time, and reports readiness and completion to software and other logic.
//  Also holds the USB chip in reset at power-up.
// PARAMETERS
//  ASSERT_CYCLES  500   min cycles usb_rst_n held low (10 us @ 50 MHz); >=2
//  SETTLE_CYCLES  2500  cycles after release before usb_ready (50 us @ 50 MHz); >=2
//  CNT_W          16    timer width; ASSERT_CYCLES, SETTLE_CYCLES < 2**CNT_W
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  rst_req    in   1   level reset request from PIO out_port (same clock domain)
//  usb_rst_n  out  1   reset to USB controller, active low, registered
//  usb_ready  out  1   1 = controller out of reset and settled, registered
//  busy       out  1   1 = in HOLD or SETTLE (= ~usb_ready), registered
//  rst_done   out  1   1-cycle pulse in first READY cycle after each sequence
//  rst_count  out  8   software-requested resets accepted, saturating at 255
// BEHAVIOUR
//  Reset (reset_n=0, async): state=HOLD, timer=0, usb_rst_n=0, usb_ready=0,
//   busy=1, rst_done=0, rst_count=0. Applies immediately, from any state.
//  States (Moore; all outputs are flops updated with state):
//   HOLD: usb_rst_n=0. Entry clears timer. Each cycle: timer++ while
//    timer<ASSERT_CYCLES-1, then saturates. Exit to SETTLE when
//    timer==ASSERT_CYCLES-1 and rst_req==0; else stay.
//    -> low width = max(ASSERT_CYCLES, cycles rst_req stays high after entry).
//   SETTLE: usb_rst_n=1, usb_ready=0. Entry clears timer; timer++ each cycle.
//    rst_req==1 -> HOLD (timer cleared, rst_count++), takes priority over expiry.
//    Else timer==SETTLE_CYCLES-1 -> READY.
//   READY: usb_rst_n=1, usb_ready=1, busy=0. rst_req==1 -> HOLD, rst_count++.
//  Latency: rst_req=1 sampled at edge N (in READY/SETTLE) -> usb_rst_n=0, busy=1
//   after edge N (visible cycle N+1). One edge, no extra sync stages.
//  rst_done: 1 exactly in the first cycle of READY; 0 otherwise, incl. power-up
//   sequence (power-up does also pulse rst_done when READY first reached).
//  rst_count: +1 on each HOLD entry caused by rst_req; not on power-up reset;
//   holds at 255 (no wrap). Cleared only by reset_n.
//  rst_req held high continuously: stays in HOLD indefinitely, counted once.
//  rst_req high on the cycle HOLD exits condition met: stays HOLD (no exit).
//  Illegal state encodings recover to HOLD with timer=0.
// TESTING (ASSERT_CYCLES=4, SETTLE_CYCLES=6)
//  Power-up: release reset_n, rst_req=0 -> usb_rst_n low 4 cycles, then high 6
//   cycles, then usb_ready=1, rst_done high 1 cycle, rst_count=0.
//  In READY, 1-cycle rst_req pulse -> usb_rst_n low next cycle for exactly 4
//   cycles, 6 SETTLE cycles, usb_ready=1, rst_done pulse, rst_count=1.
//  In READY, rst_req high 20 cycles -> usb_rst_n low exactly 20 cycles,
//   rst_count +1 only, usb_ready returns 6 cycles after release.
//  rst_req pulse at SETTLE cycle 3 -> back to HOLD next cycle, new 4-cycle low,
//   full 6-cycle SETTLE, rst_count +1, single rst_done at end.
//  300 back-to-back request/complete sequences -> rst_count stops at 255.
//  reset_n low mid-SETTLE and mid-READY -> same-cycle usb_rst_n=0, usb_ready=0,
//   rst_count=0, no rst_done; power-up sequence repeats after release.

Source files
------------

// File: rtl/usb_rst_sequencer.sv
// USB host controller reset sequencer: power-up and software reset,
// minimum assert width, post-release settle time, completion reporting.
module usb_rst_sequencer #(
  parameter int unsigned ASSERT_CYCLES = 500,
  parameter int unsigned SETTLE_CYCLES = 2500,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rst_req,
  output logic       usb_rst_n,
  output logic       usb_ready,
  output logic       busy,
  output logic       rst_done,
  output logic [7:0] rst_count
);

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SETTLE = 2'd1,
    READY  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] A_MAX = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] S_MAX = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       count_q, count_d;
  logic             usb_rst_n_q, usb_rst_n_d;
  logic             usb_ready_q, usb_ready_d;
  logic             busy_q, busy_d;
  logic             rst_done_q, rst_done_d;
  logic             req_hit;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    req_hit = 1'b0;
    case (state_q)
      HOLD: begin
        if (timer_q == A_MAX && !rst_req) begin
          state_d = SETTLE;
          timer_d = '0;
        end else if (timer_q < A_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      SETTLE: begin
        // A new request wins over settle expiry in the same cycle
        if (rst_req) begin
          state_d = HOLD;
          timer_d = '0;
          req_hit = 1'b1;
        end else if (timer_q == S_MAX) begin
          state_d = READY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      READY: begin
        if (rst_req) begin
          state_d = HOLD;
          timer_d = '0;
          req_hit = 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (req_hit && count_q != 8'hFF) begin
      count_d = count_q + 8'd1;
    end
    usb_rst_n_d = (state_d != HOLD);
    usb_ready_d = (state_d == READY);
    busy_d      = (state_d != READY);
    rst_done_d  = (state_q == SETTLE) && (state_d == READY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HOLD;
      timer_q     <= '0;
      count_q     <= '0;
      usb_rst_n_q <= 1'b0;
      usb_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      usb_rst_n_q <= usb_rst_n_d;
      usb_ready_q <= usb_ready_d;
      busy_q      <= busy_d;
      rst_done_q  <= rst_done_d;
    end
  end

  assign usb_rst_n = usb_rst_n_q;
  assign usb_ready = usb_ready_q;
  assign busy      = busy_q;
  assign rst_done  = rst_done_q;
  assign rst_count = count_q;

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Directed bench for usb_rst_sequencer with ASSERT_CYCLES=4,
// SETTLE_CYCLES=6; outputs sampled on the falling clock edge.
module tb_usb_rst_sequencer;

  logic       clk;
  logic       reset_n;
  logic       rst_req;
  logic       usb_rst_n;
  logic       usb_ready;
  logic       busy;
  logic       rst_done;
  logic [7:0] rst_count;

  int n_cmp;
  int n_bad;

  usb_rst_sequencer #(
    .ASSERT_CYCLES(4),
    .SETTLE_CYCLES(6),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rst_req(rst_req),
    .usb_rst_n(usb_rst_n),
    .usb_ready(usb_ready),
    .busy(busy),
    .rst_done(rst_done),
    .rst_count(rst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  // Starts on the first visible low cycle; keeps rst_req high for
  // req_more further cycles. Returns one cycle after READY is reached.
  task automatic run_seq(input int req_more,
                         output int low, output int settle,
                         output int done_first, output int done_other,
                         output int busy_bad);
    low = 0; settle = 0; done_first = 0; done_other = 0; busy_bad = 0;
    while (usb_rst_n === 1'b0 && low < 200) begin
      rst_req = (low < req_more);
      if (rst_done !== 1'b0) done_other++;
      if (busy !== 1'b1 || usb_ready !== 1'b0) busy_bad++;
      low++;
      cyc();
    end
    rst_req = 1'b0;
    while (usb_rst_n === 1'b1 && usb_ready === 1'b0 && settle < 200) begin
      if (rst_done !== 1'b0) done_other++;
      if (busy !== 1'b1) busy_bad++;
      settle++;
      cyc();
    end
    done_first = int'(rst_done);
    if (busy !== 1'b0 || usb_rst_n !== 1'b1) busy_bad++;
    cyc();
    if (rst_done !== 1'b0) done_other++;
  endtask

  task automatic test_reset();
    rst_req = 1'b0;
    reset_n = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if ({usb_rst_n, usb_ready, busy, rst_done} !== 4'b0010) begin
      n_bad++;
      $display("FAIL reset_outputs got %b want 0010",
               {usb_rst_n, usb_ready, busy, rst_done});
    end
    n_cmp++;
    if (rst_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_count got %0d want 0", rst_count);
    end
  endtask

  task automatic test_powerup();
    int lo, st, df, dx, bb;
    reset_n = 1'b1;
    run_seq(0, lo, st, df, dx, bb);
    n_cmp++;
    if (lo != 4) begin
      n_bad++;
      $display("FAIL pwr_low got %0d want 4", lo);
    end
    n_cmp++;
    if (st != 6) begin
      n_bad++;
      $display("FAIL pwr_settle got %0d want 6", st);
    end
    n_cmp++;
    if (df != 1 || dx != 0) begin
      n_bad++;
      $display("FAIL pwr_done got first=%0d extra=%0d want 1/0", df, dx);
    end
    n_cmp++;
    if (bb != 0) begin
      n_bad++;
      $display("FAIL pwr_busy got %0d bad cycles want 0", bb);
    end
    n_cmp++;
    if (rst_count !== 8'd0) begin
      n_bad++;
      $display("FAIL pwr_count got %0d want 0", rst_count);
    end
  endtask

  task automatic test_pulse();
    int lo, st, df, dx, bb;
    rst_req = 1'b1;
    cyc();
    run_seq(0, lo, st, df, dx, bb);
    n_cmp++;
    if (lo != 4 || st != 6) begin
      n_bad++;
      $display("FAIL pulse_timing got low=%0d settle=%0d want 4/6", lo, st);
    end
    n_cmp++;
    if (df != 1 || dx != 0 || bb != 0) begin
      n_bad++;
      $display("FAIL pulse_flags got done=%0d extra=%0d busy_bad=%0d want 1/0/0",
               df, dx, bb);
    end
    n_cmp++;
    if (rst_count !== 8'd1) begin
      n_bad++;
      $display("FAIL pulse_count got %0d want 1", rst_count);
    end
  endtask

  task automatic test_long_req();
    int lo, st, df, dx, bb;
    rst_req = 1'b1;
    cyc();
    run_seq(19, lo, st, df, dx, bb);
    n_cmp++;
    if (lo != 20 || st != 6) begin
      n_bad++;
      $display("FAIL long_timing got low=%0d settle=%0d want 20/6", lo, st);
    end
    n_cmp++;
    if (df != 1 || dx != 0) begin
      n_bad++;
      $display("FAIL long_done got first=%0d extra=%0d want 1/0", df, dx);
    end
    n_cmp++;
    if (rst_count !== 8'd2) begin
      n_bad++;
      $display("FAIL long_count got %0d want 2", rst_count);
    end
  endtask

  task automatic test_settle_abort();
    int lo, st, df, dx, bb;
    int pre_done;
    pre_done = 0;
    rst_req = 1'b1;
    cyc();
    rst_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (rst_done !== 1'b0) pre_done++;
      cyc();
    end
    n_cmp++;
    if (usb_rst_n !== 1'b1 || usb_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_in_settle got rst_n=%b ready=%b want 1/0",
               usb_rst_n, usb_ready);
    end
    rst_req = 1'b1;
    cyc();
    n_cmp++;
    if (usb_rst_n !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_latency got rst_n=%b busy=%b want 0/1",
               usb_rst_n, busy);
    end
    run_seq(0, lo, st, df, dx, bb);
    n_cmp++;
    if (lo != 4 || st != 6) begin
      n_bad++;
      $display("FAIL abort_timing got low=%0d settle=%0d want 4/6", lo, st);
    end
    n_cmp++;
    if (df != 1 || dx != 0 || pre_done != 0) begin
      n_bad++;
      $display("FAIL abort_done got first=%0d extra=%0d pre=%0d want 1/0/0",
               df, dx, pre_done);
    end
    n_cmp++;
    if (rst_count !== 8'd4) begin
      n_bad++;
      $display("FAIL abort_count got %0d want 4", rst_count);
    end
  endtask

  task automatic test_back_to_back();
    int lo, st, df, dx, bb;
    int bad_seq;
    bad_seq = 0;
    for (int i = 0; i < 300; i++) begin
      rst_req = 1'b1;
      cyc();
      run_seq(0, lo, st, df, dx, bb);
      if (lo != 4 || st != 6 || df != 1 || dx != 0) bad_seq++;
      if (i == 250) begin
        n_cmp++;
        if (rst_count !== 8'd255) begin
          n_bad++;
          $display("FAIL b2b_count_255 got %0d want 255", rst_count);
        end
      end
    end
    n_cmp++;
    if (bad_seq != 0) begin
      n_bad++;
      $display("FAIL b2b_timing got %0d bad sequences want 0", bad_seq);
    end
    n_cmp++;
    if (rst_count !== 8'd255) begin
      n_bad++;
      $display("FAIL b2b_saturate got %0d want 255", rst_count);
    end
  endtask

  task automatic test_async_reset(input int in_ready);
    int lo, st, df, dx, bb;
    rst_req = 1'b1;
    cyc();
    rst_req = 1'b0;
    for (int i = 0; i < (in_ready != 0 ? 12 : 6); i++) cyc();
    n_cmp++;
    if (usb_ready !== (in_ready != 0) || usb_rst_n !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_pre%0d got ready=%b rst_n=%b want %0d/1",
               in_ready, usb_ready, usb_rst_n, in_ready);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({usb_rst_n, usb_ready, busy, rst_done} !== 4'b0010
        || rst_count !== 8'd0) begin
      n_bad++;
      $display("FAIL areset_now%0d got %b cnt=%0d want 0010 cnt=0",
               in_ready, {usb_rst_n, usb_ready, busy, rst_done}, rst_count);
    end
    cyc();
    cyc();
    reset_n = 1'b1;
    run_seq(0, lo, st, df, dx, bb);
    n_cmp++;
    if (lo != 4 || st != 6 || df != 1 || dx != 0 || rst_count !== 8'd0) begin
      n_bad++;
      $display("FAIL areset_redo%0d got low=%0d settle=%0d done=%0d/%0d cnt=%0d want 4/6/1/0/0",
               in_ready, lo, st, df, dx, rst_count);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_req = 1'b0;
    reset_n = 1'b0;
    test_reset();
    test_powerup();
    test_pulse();
    test_long_req();
    test_settle_abort();
    test_back_to_back();
    test_async_reset(0);
    test_async_reset(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
